register_file_dual_commit: RTL and testbench
============================================

Name: register_file_dual_commit

Overview:
- Architectural register file with rename-tag (dependency) tracking for the out-of-order core.
- Sits between Dispatcher and RoB.
- Dispatch reads two source operands as value or RoB tag, and renames one destination per cycle.
- Retires up to COMMIT_W instructions per cycle, in program order, with same-cycle forwarding.
- Generalises the single-commit file: parametrised XLEN, register count and RoB depth; hardwired x0; explicit flush input.

Parameters:
- XLEN, 32, data width of each register.
- REG_WIDTH, 5, architectural register index width (REG_SIZE = 2^REG_WIDTH).
- ROB_WIDTH, 8, RoB index width.
- COMMIT_W, 2, commit channels per cycle (1 or 2); channel 0 is the oldest.

Ports:
- Sys_clk  in  1  clock, rising-edge.
- Sys_rst  in  1  reset, asynchronous, active-high.
- Sys_rdy  in  1  global enable; low = hold all state.
- DPRF_en  in  1  dispatch valid: rename rd this cycle.
- DPRF_rs1  in  REG_WIDTH+1  source 1; value 2^REG_WIDTH (NON_REG) = no operand.
- DPRF_rs2  in  REG_WIDTH+1  source 2, same encoding.
- DPRF_rd  in  REG_WIDTH+1  destination, same encoding.
- DPRF_RoB_index  in  ROB_WIDTH  RoB entry producing rd.
- RFDP_Qj  out  ROB_WIDTH+1  rs1 tag; 2^ROB_WIDTH (NON_DEP) = value ready.
- RFDP_Qk  out  ROB_WIDTH+1  rs2 tag, same encoding.
- RFDP_Vj  out  XLEN  rs1 value; valid when Qj = NON_DEP.
- RFDP_Vk  out  XLEN  rs2 value; valid when Qk = NON_DEP.
- RoBRF_flush  in  1  mispredict flush; clears all tags.
- RoBRF_en  in  COMMIT_W  per-channel commit valid.
- RoBRF_rd  in  COMMIT_W*(REG_WIDTH+1)  per-channel rd, packed with channel 0 in the LSBs.
- RoBRF_RoB_index  in  COMMIT_W*ROB_WIDTH  per-channel RoB index, packed.
- RoBRF_value  in  COMMIT_W*XLEN  per-channel result, packed.

Behaviour:
- State: regs[REG_SIZE] of XLEN bits; dep[REG_SIZE] of ROB_WIDTH+1 bits.
- Reset (async): all regs = 0, all dep = NON_DEP. Outputs are combinational, so during reset RFDP_Q* = NON_DEP and RFDP_V* = 0 for any rs.
- Read path is combinational, 0-cycle latency. Per source s:
  - s = NON_REG or s = 0: Q = NON_DEP, V = 0.
  - Else, if commit channel c is enabled with RoB_index[c] = dep[s]: Q = NON_DEP, V = value[c]. If both channels match, the highest c wins (unreachable with unique tags, defined anyway).
  - Else if RoBRF_flush: Q = NON_DEP, V = regs[s].
  - Else: Q = dep[s]; V = regs[s] when dep[s] = NON_DEP, otherwise 0.
- Sequential update on posedge Sys_clk, only when Sys_rdy = 1.
- Commit, for each enabled channel c in order 0..COMMIT_W-1:
  - When rd[c] is neither NON_REG nor 0: regs[rd[c]] <= value[c].
  - Same rd on both channels: channel 1 value wins.
  - Tag clear: dep[rd[c]] <= NON_DEP only if dep[rd[c]] = RoB_index[c] and no same-cycle dispatch renames that rd.
- Flush, when RoBRF_flush = 1:
  - Commits in the same cycle still write regs; they are older than the flushing branch.
  - Every dep <= NON_DEP.
  - DPRF_en is ignored (no rename).
- Rename, when RoBRF_flush = 0, DPRF_en = 1, and DPRF_rd is neither NON_REG nor 0: dep[DPRF_rd] <= DPRF_RoB_index. This overrides any same-cycle tag clear of that register.
- Register 0: never written; dep[0] stays NON_DEP.
- Sys_rdy = 0: no state change. The combinational read path still operates.
- Reset mid-operation: immediate return to the reset state; no pending commit is retained.

Optional Feature:
- Macro RF_DEBUG_PORT_EN.
- When defined, the block adds:
  - input DBG_rd_addr [REG_WIDTH-1:0];
  - output DBG_rd_data [XLEN-1:0], the registered value regs[DBG_rd_addr], 1-cycle latency, 0 during reset;
  - output DBG_busy [REG_SIZE-1:0], where bit i = (dep[i] != NON_DEP), combinational.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then dispatch rs1=3, rs2=NON_REG -> Qj=Qk=NON_DEP, Vj=0, Vk=0.
- Dispatch rd=5, tag 0x12; next cycle dispatch rs1=5 -> Qj=0x12. Then commit ch0 rd=5, idx 0x12, value 0xDEADBEEF while dispatching rs1=5 -> same cycle Qj=NON_DEP, Vj=0xDEADBEEF; next cycle dep[5]=NON_DEP, regs[5]=0xDEADBEEF.
- Same cycle: commit ch0 rd=7 idx 0x03 (dep[7]=0x03) and dispatch rd=7 idx 0x04 -> dep[7]=0x04, regs[7] updated; later read rs1=7 gives Qj=0x04.
- Dual commit: ch0 rd=9 val 1, ch1 rd=9 val 2, both tags matching -> regs[9]=2, dep[9]=NON_DEP. Also commit rd=0 val 5 -> x0 reads 0.
- Rename rd 1..4, then RoBRF_flush with ch0 commit rd=2 val 0x55 and DPRF_en rd=6 -> all dep = NON_DEP, regs[2]=0x55, dep[6]=NON_DEP.
- Assert Sys_rst asynchronously mid-cycle with deps pending -> outputs immediately NON_DEP/0; Sys_rdy=0 cycles leave regs and dep unchanged.

Source files
------------

// File: rtl/register_file_dual_commit_if.sv
// -----------------------------------------------------------------------------
// register_file_dual_commit_if
// Bundles the register file's two traffic groups:
//   Dispatch side : DPRF_en, DPRF_rs1/rs2/rd (REG_WIDTH+1, top value = no
//                   register), DPRF_RoB_index, and the returned operand
//                   RFDP_Qj/Qk (ROB_WIDTH+1, top value = no dependency),
//                   RFDP_Vj/Vk.
//   RoB side      : RoBRF_flush, RoBRF_en[COMMIT_W], and the packed per-channel
//                   RoBRF_rd / RoBRF_RoB_index / RoBRF_value (channel 0 in the
//                   LSBs, channel 0 oldest).
// master = Dispatcher/RoB view, slave = register file view.
// -----------------------------------------------------------------------------
interface register_file_dual_commit_if #(
    parameter int XLEN      = 32,
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 8,
    parameter int COMMIT_W  = 2
);
    logic                               DPRF_en;
    logic [REG_WIDTH:0]                 DPRF_rs1;
    logic [REG_WIDTH:0]                 DPRF_rs2;
    logic [REG_WIDTH:0]                 DPRF_rd;
    logic [ROB_WIDTH-1:0]               DPRF_RoB_index;
    logic [ROB_WIDTH:0]                 RFDP_Qj;
    logic [ROB_WIDTH:0]                 RFDP_Qk;
    logic [XLEN-1:0]                    RFDP_Vj;
    logic [XLEN-1:0]                    RFDP_Vk;
    logic                               RoBRF_flush;
    logic [COMMIT_W-1:0]                RoBRF_en;
    logic [COMMIT_W*(REG_WIDTH+1)-1:0]  RoBRF_rd;
    logic [COMMIT_W*ROB_WIDTH-1:0]      RoBRF_RoB_index;
    logic [COMMIT_W*XLEN-1:0]           RoBRF_value;

    modport master (
        output DPRF_en, DPRF_rs1, DPRF_rs2, DPRF_rd, DPRF_RoB_index,
        output RoBRF_flush, RoBRF_en, RoBRF_rd, RoBRF_RoB_index, RoBRF_value,
        input  RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
    );

    modport slave (
        input  DPRF_en, DPRF_rs1, DPRF_rs2, DPRF_rd, DPRF_RoB_index,
        input  RoBRF_flush, RoBRF_en, RoBRF_rd, RoBRF_RoB_index, RoBRF_value,
        output RFDP_Qj, RFDP_Qk, RFDP_Vj, RFDP_Vk
    );
endinterface

// File: rtl/register_file_dual_commit.sv
// -----------------------------------------------------------------------------
// register_file_dual_commit
// Architectural register file with rename-tag tracking. Dispatch reads two
// source operands (value or producing RoB tag) combinationally and renames one
// destination per cycle; the RoB retires up to COMMIT_W results per cycle in
// program order, with same-cycle forwarding of committing values to readers.
//
// Ports:
//   Sys_clk  - rising-edge clock
//   Sys_rst  - asynchronous active-high reset
//   Sys_rdy  - global enable, low holds all state (reads still work)
//   bus      - register_file_dual_commit_if.slave (dispatch + commit groups)
// Optional (macro RF_DEBUG_PORT_EN):
//   DBG_rd_addr - debug read address
//   DBG_rd_data - registered regs[DBG_rd_addr], one cycle latency
//   DBG_busy    - per-register "rename tag pending" flags
//
// Interface parameters must match the parameters of this module.
// -----------------------------------------------------------------------------
module register_file_dual_commit #(
    parameter int XLEN      = 32,
    parameter int REG_WIDTH = 5,
    parameter int ROB_WIDTH = 8,
    parameter int COMMIT_W  = 2
) (
    input  logic                          Sys_clk,
    input  logic                          Sys_rst,
    input  logic                          Sys_rdy,
    register_file_dual_commit_if.slave    bus
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [REG_WIDTH-1:0]          DBG_rd_addr,
    output logic [XLEN-1:0]               DBG_rd_data,
    output logic [(1<<REG_WIDTH)-1:0]     DBG_busy
`endif
);

    localparam int REG_SIZE = 1 << REG_WIDTH;
    localparam int RDW      = REG_WIDTH + 1;
    // Top code of the tag space marks "value is ready, no producer pending".
    localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

    // Architectural state and its next-state image.
    logic [XLEN-1:0]      regs_q [REG_SIZE];
    logic [XLEN-1:0]      regs_d [REG_SIZE];
    logic [ROB_WIDTH:0]   dep_q  [REG_SIZE];
    logic [ROB_WIDTH:0]   dep_d  [REG_SIZE];

    // Unpacked commit channels.
    logic [REG_WIDTH:0]   c_rd_s  [COMMIT_W];
    logic [ROB_WIDTH-1:0] c_idx_s [COMMIT_W];
    logic [XLEN-1:0]      c_val_s [COMMIT_W];
    logic                 c_wr_s  [COMMIT_W];

    // Read path per source operand (0 = rs1, 1 = rs2).
    logic [REG_WIDTH:0]   src_s   [2];
    logic [ROB_WIDTH:0]   q_s     [2];
    logic [XLEN-1:0]      v_s     [2];

    logic                 ren_s;

    // True for an encoding that names a writable architectural register:
    // excludes x0 and everything with the top (NON_REG) bit set.
    function automatic logic is_arch(input logic [REG_WIDTH:0] s);
        return (s[REG_WIDTH] == 1'b0) && (s[REG_WIDTH-1:0] != {REG_WIDTH{1'b0}});
    endfunction

    // Split the packed commit buses into per-channel fields.
    always_comb begin
        for (int c = 0; c < COMMIT_W; c++) begin
            c_rd_s[c]  = bus.RoBRF_rd[c*RDW +: RDW];
            c_idx_s[c] = bus.RoBRF_RoB_index[c*ROB_WIDTH +: ROB_WIDTH];
            c_val_s[c] = bus.RoBRF_value[c*XLEN +: XLEN];
            c_wr_s[c]  = bus.RoBRF_en[c] && is_arch(c_rd_s[c]);
        end
    end

    // A flush cancels every speculative rename, including this cycle's.
    assign ren_s = !bus.RoBRF_flush && bus.DPRF_en && is_arch(bus.DPRF_rd);

    assign src_s[0] = bus.DPRF_rs1;
    assign src_s[1] = bus.DPRF_rs2;

    // Combinational operand read with same-cycle commit forwarding.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            logic [ROB_WIDTH:0] dep_rd;
            logic               hit;
            logic [XLEN-1:0]    fwd;
            logic               match;
            dep_rd = dep_q[src_s[k][REG_WIDTH-1:0]];
            hit    = 1'b0;
            fwd    = {XLEN{1'b0}};
            q_s[k] = NON_DEP;
            v_s[k] = {XLEN{1'b0}};
            // Later channel overrides an earlier one if both carry the tag.
            for (int c = 0; c < COMMIT_W; c++) begin
                match = bus.RoBRF_en[c] && ({1'b0, c_idx_s[c]} == dep_rd);
                hit   = hit | match;
                fwd   = match ? c_val_s[c] : fwd;
            end
            if (Sys_rst || !is_arch(src_s[k])) begin
                q_s[k] = NON_DEP;
                v_s[k] = {XLEN{1'b0}};
            end else if (hit) begin
                q_s[k] = NON_DEP;
                v_s[k] = fwd;
            end else if (bus.RoBRF_flush) begin
                q_s[k] = NON_DEP;
                v_s[k] = regs_q[src_s[k][REG_WIDTH-1:0]];
            end else begin
                q_s[k] = dep_rd;
                v_s[k] = (dep_rd == NON_DEP) ? regs_q[src_s[k][REG_WIDTH-1:0]]
                                             : {XLEN{1'b0}};
            end
        end
    end

    assign bus.RFDP_Qj = q_s[0];
    assign bus.RFDP_Qk = q_s[1];
    assign bus.RFDP_Vj = v_s[0];
    assign bus.RFDP_Vk = v_s[1];

    // Next-state: commit writes, tag clears, flush and rename priority.
    always_comb begin
        for (int i = 0; i < REG_SIZE; i++) begin
            logic [XLEN-1:0] nxt_v;
            logic            clr;
            logic            wr;
            nxt_v = regs_q[i];
            clr   = 1'b0;
            for (int c = 0; c < COMMIT_W; c++) begin
                wr    = c_wr_s[c] && (c_rd_s[c][REG_WIDTH-1:0] == REG_WIDTH'(i));
                nxt_v = wr ? c_val_s[c] : nxt_v;
                clr   = clr | (wr && (dep_q[i] == {1'b0, c_idx_s[c]}));
            end
            regs_d[i] = nxt_v;
            // Rename of the same register beats a tag clear: the new producer
            // is younger than the one retiring.
            if (bus.RoBRF_flush) begin
                dep_d[i] = NON_DEP;
            end else if (ren_s && (bus.DPRF_rd[REG_WIDTH-1:0] == REG_WIDTH'(i))) begin
                dep_d[i] = {1'b0, bus.DPRF_RoB_index};
            end else if (clr) begin
                dep_d[i] = NON_DEP;
            end else begin
                dep_d[i] = dep_q[i];
            end
        end
    end

    // State registers; Sys_rdy low freezes everything.
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
                dep_q[i]  <= NON_DEP;
            end
        end else if (Sys_rdy) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                regs_q[i] <= regs_d[i];
                dep_q[i]  <= dep_d[i];
            end
        end
    end

`ifdef RF_DEBUG_PORT_EN
    logic [XLEN-1:0] dbg_data_q;

    // Debug snapshot register; observes state and is not frozen by Sys_rdy.
    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            dbg_data_q <= {XLEN{1'b0}};
        end else begin
            dbg_data_q <= regs_q[DBG_rd_addr];
        end
    end

    assign DBG_rd_data = dbg_data_q;

    // Busy map: one bit per register with a rename tag outstanding.
    always_comb begin
        for (int i = 0; i < REG_SIZE; i++) begin
            DBG_busy[i] = (dep_q[i] != NON_DEP);
        end
    end
`else
    // Debug port absent in this build.
`endif

endmodule

// File: tb/tb_register_file_dual_commit.sv
module tb_register_file_dual_commit;

    localparam logic [5:0] NR = 6'd32;
    localparam logic [8:0] ND = 9'h100;

    typedef struct packed {
        logic        rdy;
        logic        dp;
        logic [5:0]  rd;
        logic [7:0]  idx;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic        flush;
        logic [1:0]  cen;
        logic [5:0]  crd0;
        logic [7:0]  cidx0;
        logic [31:0] cval0;
        logic [5:0]  crd1;
        logic [7:0]  cidx1;
        logic [31:0] cval1;
        logic [8:0]  eqj;
        logic [31:0] evj;
        logic [8:0]  eqk;
        logic [31:0] evk;
    } vec_t;

    logic Sys_clk;
    logic Sys_rst;
    logic Sys_rdy;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];
    vec_t cur;

    // Reference model: -1 means no producer pending.
    int          mdep  [32];
    logic [31:0] mregs [32];

    register_file_dual_commit_if #(.XLEN(32), .REG_WIDTH(5), .ROB_WIDTH(8), .COMMIT_W(2)) bus();

`ifdef RF_DEBUG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] dbg_busy;
    assign dbg_addr = 5'd0;
`endif

    register_file_dual_commit #(.XLEN(32), .REG_WIDTH(5), .ROB_WIDTH(8), .COMMIT_W(2)) dut (
        .Sys_clk (Sys_clk),
        .Sys_rst (Sys_rst),
        .Sys_rdy (Sys_rdy),
        .bus     (bus)
`ifdef RF_DEBUG_PORT_EN
        ,
        .DBG_rd_addr (dbg_addr),
        .DBG_rd_data (dbg_data),
        .DBG_busy    (dbg_busy)
`endif
    );

    initial Sys_clk = 1'b0;
    always #5 Sys_clk = ~Sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic dp, input logic [5:0] rd,
                                input logic [7:0] idx, input logic [5:0] rs1, input logic [5:0] rs2,
                                input logic flush, input logic [1:0] cen,
                                input logic [5:0] crd0, input logic [7:0] cidx0, input logic [31:0] cval0,
                                input logic [5:0] crd1, input logic [7:0] cidx1, input logic [31:0] cval1,
                                input logic [8:0] eqj, input logic [31:0] evj,
                                input logic [8:0] eqk, input logic [31:0] evk);
        vec_t v;
        v.rdy = rdy; v.dp = dp; v.rd = rd; v.idx = idx; v.rs1 = rs1; v.rs2 = rs2;
        v.flush = flush; v.cen = cen;
        v.crd0 = crd0; v.cidx0 = cidx0; v.cval0 = cval0;
        v.crd1 = crd1; v.cidx1 = cidx1; v.cval1 = cval1;
        v.eqj = eqj; v.evj = evj; v.eqk = eqk; v.evk = evk;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        Sys_rdy             = v.rdy;
        bus.DPRF_en         = v.dp;
        bus.DPRF_rd         = v.rd;
        bus.DPRF_RoB_index  = v.idx;
        bus.DPRF_rs1        = v.rs1;
        bus.DPRF_rs2        = v.rs2;
        bus.RoBRF_flush     = v.flush;
        bus.RoBRF_en        = v.cen;
        bus.RoBRF_rd        = {v.crd1, v.crd0};
        bus.RoBRF_RoB_index = {v.cidx1, v.cidx0};
        bus.RoBRF_value     = {v.cval1, v.cval0};
    endtask

    // Expected {Q, V} for a source read, from the operand rules.
    function automatic logic [40:0] mread(input int s);
        int          d;
        logic        hit;
        logic [31:0] fv;
        if (s == 0 || s >= 32) return {ND, 32'h0};
        d   = mdep[s];
        hit = 1'b0;
        fv  = 32'h0;
        if (d >= 0) begin
            if (cur.cen[0] && int'(cur.cidx0) == d) begin hit = 1'b1; fv = cur.cval0; end
            if (cur.cen[1] && int'(cur.cidx1) == d) begin hit = 1'b1; fv = cur.cval1; end
        end
        if (hit) return {ND, fv};
        if (cur.flush || d < 0) return {ND, mregs[s]};
        return {9'(d), 32'h0};
    endfunction

    // Advance the model by one enabled clock.
    task automatic mstep();
        int  rd_c [2];
        int  ix_c [2];
        logic [31:0] vl_c [2];
        bit  ren;
        if (!cur.rdy) return;
        rd_c[0] = int'(cur.crd0); ix_c[0] = int'(cur.cidx0); vl_c[0] = cur.cval0;
        rd_c[1] = int'(cur.crd1); ix_c[1] = int'(cur.cidx1); vl_c[1] = cur.cval1;
        ren = !cur.flush && cur.dp && cur.rd != 6'd0 && cur.rd < 6'd32;
        for (int c = 0; c < 2; c++) begin
            if (cur.cen[c] && rd_c[c] != 0 && rd_c[c] < 32) begin
                mregs[rd_c[c]] = vl_c[c];
                if (mdep[rd_c[c]] == ix_c[c] && !(ren && int'(cur.rd) == rd_c[c]))
                    mdep[rd_c[c]] = -1;
            end
        end
        if (cur.flush) begin
            for (int i = 0; i < 32; i++) mdep[i] = -1;
        end else if (ren) begin
            mdep[int'(cur.rd)] = int'(cur.idx);
        end
    endtask

    function automatic logic [5:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? NR : 6'(r);
    endfunction

    initial begin
        logic [40:0] e;
        n_tests = 0;
        n_fail  = 0;

        // Directed vectors: inputs applied before an edge, outputs compared
        // before that edge (state reflects all previous vectors).
        vecs.push_back(mk(1,0,NR,8'h00, 6'd3,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,1,6'd5,8'h12, NR,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd5,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, 9'h012,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd5,NR, 0,2'b01, 6'd5,8'h12,32'hDEADBEEF, NR,8'h00,32'h0, ND,32'hDEADBEEF,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd5,6'd5, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'hDEADBEEF,ND,32'hDEADBEEF));
        vecs.push_back(mk(1,1,6'd7,8'h03, NR,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,1,6'd7,8'h04, 6'd7,NR, 0,2'b01, 6'd7,8'h03,32'h77, NR,8'h00,32'h0, ND,32'h77,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd7,6'd7, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, 9'h004,32'h0,9'h004,32'h0));
        vecs.push_back(mk(1,1,6'd9,8'h20, 6'd9,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd9,NR, 0,2'b11, 6'd9,8'h20,32'h1, 6'd9,8'h21,32'h2, ND,32'h1,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd9,6'd0, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h2,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd0,NR, 0,2'b01, 6'd0,8'h05,32'h5, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd0,6'd7, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,9'h004,32'h0));
        for (int r = 1; r <= 4; r++)
            vecs.push_back(mk(1,1,6'(r),8'(8'h30 + r), NR,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd2,6'd4, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, 9'h032,32'h0,9'h034,32'h0));
        vecs.push_back(mk(1,1,6'd6,8'h50, 6'd2,6'd3, 1,2'b01, 6'd2,8'h40,32'h55, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd2,6'd6, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h55,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd1,6'd4, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(0,1,6'd8,8'h60, 6'd8,NR, 0,2'b01, 6'd8,8'h61,32'h88, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd8,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(1,1,6'd8,8'h62, NR,NR, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        vecs.push_back(mk(0,0,NR,8'h00, 6'd8,NR, 0,2'b01, 6'd8,8'h62,32'h9, NR,8'h00,32'h0, ND,32'h9,ND,32'h0));
        vecs.push_back(mk(1,0,NR,8'h00, 6'd8,6'd5, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, 9'h062,32'h0,ND,32'hDEADBEEF));

        // Reset: outputs idle even with a forwarding commit presented.
        Sys_rst = 1'b1;
        apply(mk(1,0,NR,8'h00, 6'd5,6'd3, 0,2'b01, 6'd5,8'h00,32'h1234, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        repeat (2) @(posedge Sys_clk);
        #2;
        check("reset Qj", 64'(bus.RFDP_Qj), 64'(ND));
        check("reset Vj", 64'(bus.RFDP_Vj), 64'h0);
        check("reset Qk", 64'(bus.RFDP_Qk), 64'(ND));
        @(negedge Sys_clk);
        apply(vecs[0]);
        Sys_rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge Sys_clk);
            #1 apply(vecs[i]);
            #3;
            check($sformatf("vec%0d Qj", i), 64'(bus.RFDP_Qj), 64'(vecs[i].eqj));
            check($sformatf("vec%0d Vj", i), 64'(bus.RFDP_Vj), 64'(vecs[i].evj));
            check($sformatf("vec%0d Qk", i), 64'(bus.RFDP_Qk), 64'(vecs[i].eqk));
            check($sformatf("vec%0d Vk", i), 64'(bus.RFDP_Vk), 64'(vecs[i].evk));
        end

        // Asynchronous reset in mid-cycle with a tag pending on x8.
        @(posedge Sys_clk);
        #1 apply(mk(1,0,NR,8'h00, 6'd8,6'd5, 0,2'b00, NR,8'h00,32'h0, NR,8'h00,32'h0, ND,32'h0,ND,32'h0));
        #1;
        check("prerst Qj", 64'(bus.RFDP_Qj), 64'h062);
        check("prerst Vk", 64'(bus.RFDP_Vk), 64'hDEADBEEF);
        #1 Sys_rst = 1'b1;
        #1;
        check("midrst Qj", 64'(bus.RFDP_Qj), 64'(ND));
        check("midrst Vj", 64'(bus.RFDP_Vj), 64'h0);
        check("midrst Qk", 64'(bus.RFDP_Qk), 64'(ND));
        check("midrst Vk", 64'(bus.RFDP_Vk), 64'h0);
        @(posedge Sys_clk);
        #2 Sys_rst = 1'b0;
        @(posedge Sys_clk);
        #2;
        check("postrst Qj", 64'(bus.RFDP_Qj), 64'(ND));
        check("postrst Vk", 64'(bus.RFDP_Vk), 64'h0);

        // Randomized phase against the reference model, from reset state.
        for (int i = 0; i < 32; i++) begin
            mdep[i]  = -1;
            mregs[i] = 32'h0;
        end
        for (int n = 0; n < 600; n++) begin
            cur       = '0;
            cur.rdy   = ($urandom_range(0, 7) != 0);
            cur.flush = ($urandom_range(0, 15) == 0);
            cur.dp    = 1'($urandom_range(0, 1));
            cur.rd    = pick_reg();
            cur.idx   = 8'($urandom_range(0, 15));
            cur.rs1   = pick_reg();
            cur.rs2   = pick_reg();
            cur.cen   = 2'($urandom_range(0, 3));
            cur.crd0  = pick_reg();
            cur.crd1  = pick_reg();
            cur.cidx0 = (cur.crd0 < NR && mdep[int'(cur.crd0)] >= 0 && $urandom_range(0, 3) != 0)
                        ? 8'(mdep[int'(cur.crd0)]) : 8'($urandom_range(0, 15));
            cur.cidx1 = (cur.crd1 < NR && mdep[int'(cur.crd1)] >= 0 && $urandom_range(0, 3) != 0)
                        ? 8'(mdep[int'(cur.crd1)]) : 8'($urandom_range(0, 15));
            cur.cval0 = $urandom;
            cur.cval1 = $urandom;
            @(posedge Sys_clk);
            #1 apply(cur);
            #3;
            e = mread(int'(cur.rs1));
            check($sformatf("rnd%0d Qj", n), 64'(bus.RFDP_Qj), 64'(e[40:32]));
            check($sformatf("rnd%0d Vj", n), 64'(bus.RFDP_Vj), 64'(e[31:0]));
            e = mread(int'(cur.rs2));
            check($sformatf("rnd%0d Qk", n), 64'(bus.RFDP_Qk), 64'(e[40:32]));
            check($sformatf("rnd%0d Vk", n), 64'(bus.RFDP_Vk), 64'(e[31:0]));
            mstep();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
